onchip_mem_arbiter: RTL and testbench

Two-requester arbiter that shares the single-port on-chip RAM (32-bit, 15-bit word address, 1-cycle read latency) between the Nios data master (port m0) and the segment-display refresh/DMA master (port m1). It sits between the two Avalon-MM masters and the RAM's s1 slave. It grants one access per cycle, using round-robin with a bounded burst hold, and routes read data back to the master that issued the read.

---
 rtl/onchip_mem_arb_pkg.sv | 25 ++
 rtl/onchip_mem_arb_tagpipe.sv | 34 +++
 rtl/onchip_mem_arbiter.sv | 142 ++++++++++++++
 tb/tb_onchip_mem_arbiter.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/onchip_mem_arb_pkg.sv
// Shared types for the two-master on-chip RAM arbiter: FSM states,
// requester identifiers and the read-return tag carried down the latency pipe.
package onchip_mem_arb_pkg;

    // The state names the master that owned the grant on the previous cycle.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT0 = 2'd1,
        GRANT1 = 2'd2
    } arb_state_e;

    typedef logic port_id_t;

    localparam port_id_t PORT_M0 = 1'b0;
    localparam port_id_t PORT_M1 = 1'b1;

    // MAX_BURST tops out at 255, so an 8-bit counter always suffices.
    localparam int BURST_CNT_W = 8;

    typedef struct packed {
        logic     valid;
        port_id_t id;
    } read_tag_t;

endpackage

// File: rtl/onchip_mem_arb_tagpipe.sv
// Read-return tag pipe: one stage per RAM read-latency cycle, so a tag pushed
// with an accepted read emerges exactly when the RAM presents its data.
module onchip_mem_arb_tagpipe
    import onchip_mem_arb_pkg::*;
#(
    parameter int READ_LATENCY = 1
) (
    input  logic      clk,
    input  logic      reset,
    input  read_tag_t tag_i,
    output logic      m0_readdatavalid_o,
    output logic      m1_readdatavalid_o
);

    read_tag_t pipe_q [READ_LATENCY];

    // Shift tags one stage per clock; reset flushes every in-flight read at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < READ_LATENCY; i++) begin
                pipe_q[i] <= '0;
            end
        end else begin
            pipe_q[0] <= tag_i;
            for (int i = 1; i < READ_LATENCY; i++) begin
                pipe_q[i] <= pipe_q[i-1];
            end
        end
    end

    assign m0_readdatavalid_o = pipe_q[READ_LATENCY-1].valid && (pipe_q[READ_LATENCY-1].id == PORT_M0);
    assign m1_readdatavalid_o = pipe_q[READ_LATENCY-1].valid && (pipe_q[READ_LATENCY-1].id == PORT_M1);

endmodule

// File: rtl/onchip_mem_arbiter.sv
// Shares one single-port RAM between two Avalon-MM masters. One access per
// cycle, round-robin with a bounded burst hold, zero issue latency, and read
// data steered back to its issuer through a latency-matched tag pipe.
module onchip_mem_arbiter
    import onchip_mem_arb_pkg::*;
#(
    parameter int ADDR_W       = 15,
    parameter int DATA_W       = 32,
    parameter int BE_W         = DATA_W / 8,
    parameter int MAX_BURST    = 8,
    parameter int READ_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset,

    input  logic [ADDR_W-1:0] m0_address,
    input  logic [BE_W-1:0]   m0_byteenable,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [DATA_W-1:0] m0_writedata,
    output logic              m0_waitrequest,
    output logic [DATA_W-1:0] m0_readdata,
    output logic              m0_readdatavalid,

    input  logic [ADDR_W-1:0] m1_address,
    input  logic [BE_W-1:0]   m1_byteenable,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [DATA_W-1:0] m1_writedata,
    output logic              m1_waitrequest,
    output logic [DATA_W-1:0] m1_readdata,
    output logic              m1_readdatavalid,

    output logic [ADDR_W-1:0] mem_address,
    output logic [BE_W-1:0]   mem_byteenable,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [DATA_W-1:0] mem_writedata,
    output logic              mem_clken,
    input  logic [DATA_W-1:0] mem_readdata
);

    localparam logic [BURST_CNT_W-1:0] MAX_BURST_C = BURST_CNT_W'(MAX_BURST);

    arb_state_e              state_q, state_d;
    port_id_t                lastGrant_q, lastGrant_d;
    logic [BURST_CNT_W-1:0]  burstCnt_q, burstCnt_d;

    logic      req0, req1;
    logic      grant0, grant1;
    logic      winnerWrite;
    read_tag_t tag;

    assign req0 = m0_read | m0_write;
    assign req1 = m1_read | m1_write;

    // Register the owner of this cycle's grant, the tie-break history and the burst length.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            lastGrant_q <= PORT_M1;
            burstCnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            lastGrant_q <= lastGrant_d;
            burstCnt_q  <= burstCnt_d;
        end
    end

    // Pick this cycle's winner; the chosen state doubles as the live grant.
    always_comb begin
        state_d     = IDLE;
        lastGrant_d = lastGrant_q;
        burstCnt_d  = burstCnt_q;
        unique case (state_q)
            IDLE: begin
                if (req0 && req1) begin
                    state_d = (lastGrant_q == PORT_M0) ? GRANT1 : GRANT0;
                end else if (req0) begin
                    state_d = GRANT0;
                end else if (req1) begin
                    state_d = GRANT1;
                end
            end
            GRANT0: begin
                if (req0 && (!req1 || (burstCnt_q < MAX_BURST_C))) begin
                    state_d = GRANT0;
                end else if (req1) begin
                    state_d = GRANT1;
                end
            end
            GRANT1: begin
                if (req1 && (!req0 || (burstCnt_q < MAX_BURST_C))) begin
                    state_d = GRANT1;
                end else if (req0) begin
                    state_d = GRANT0;
                end
            end
            default: state_d = IDLE;
        endcase

        if (state_d != IDLE) begin
            lastGrant_d = (state_d == GRANT1) ? PORT_M1 : PORT_M0;
            if (state_d == state_q) begin
                burstCnt_d = (burstCnt_q < MAX_BURST_C) ? burstCnt_q + 1'b1 : MAX_BURST_C;
            end else begin
                burstCnt_d = BURST_CNT_W'(1);
            end
        end
    end

    // Route the winner to the RAM, stall only the requesting loser, and tag granted reads.
    always_comb begin
        grant0         = (state_d == GRANT0);
        grant1         = (state_d == GRANT1);
        mem_address    = grant1 ? m1_address    : m0_address;
        mem_byteenable = grant1 ? m1_byteenable : m0_byteenable;
        mem_writedata  = grant1 ? m1_writedata  : m0_writedata;
        winnerWrite    = grant1 ? m1_write      : m0_write;
        mem_chipselect = grant0 | grant1;
        mem_write      = mem_chipselect & winnerWrite;
        m0_waitrequest = req0 & ~grant0;
        m1_waitrequest = req1 & ~grant1;
        tag.valid      = mem_chipselect & ~winnerWrite;
        tag.id         = grant1 ? PORT_M1 : PORT_M0;
    end

    onchip_mem_arb_tagpipe #(
        .READ_LATENCY (READ_LATENCY)
    ) u_tagpipe (
        .clk                (clk),
        .reset              (reset),
        .tag_i              (tag),
        .m0_readdatavalid_o (m0_readdatavalid),
        .m1_readdatavalid_o (m1_readdatavalid)
    );

    assign m0_readdata = mem_readdata;
    assign m1_readdata = mem_readdata;
    assign mem_clken   = 1'b1;

endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// Bench for onchip_mem_arbiter: a READ_LATENCY=1 instance driven by a vector
// table plus a burst-hold sequence, and a READ_LATENCY=3 instance (same master
// inputs) used for the mid-read reset and latency/ordering sequences.
module tb_onchip_mem_arbiter;

    logic        clk;
    logic        reset;
    logic [14:0] m0_address, m1_address;
    logic [3:0]  m0_byteenable, m1_byteenable;
    logic        m0_read, m0_write, m1_read, m1_write;
    logic [31:0] m0_writedata, m1_writedata;

    logic        d1M0Wait, d1M0Rdv, d1M1Wait, d1M1Rdv;
    logic [31:0] d1M0Rdata, d1M1Rdata, d1MemWdata, d1MemRdata;
    logic [14:0] d1MemAddr;
    logic [3:0]  d1MemBe;
    logic        d1MemCs, d1MemWr, d1MemClken;

    logic        d3M0Wait, d3M0Rdv, d3M1Wait, d3M1Rdv;
    logic [31:0] d3M0Rdata, d3M1Rdata, d3MemWdata, d3MemRdata;
    logic [14:0] d3MemAddr;
    logic [3:0]  d3MemBe;
    logic        d3MemCs, d3MemWr, d3MemClken;

    int testsRun  = 0;
    int failCount = 0;

    onchip_mem_arbiter #(.MAX_BURST(8), .READ_LATENCY(1)) dut (
        .clk(clk), .reset(reset),
        .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
        .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(d1M0Wait),
        .m0_readdata(d1M0Rdata), .m0_readdatavalid(d1M0Rdv),
        .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
        .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(d1M1Wait),
        .m1_readdata(d1M1Rdata), .m1_readdatavalid(d1M1Rdv),
        .mem_address(d1MemAddr), .mem_byteenable(d1MemBe), .mem_chipselect(d1MemCs),
        .mem_write(d1MemWr), .mem_writedata(d1MemWdata), .mem_clken(d1MemClken),
        .mem_readdata(d1MemRdata)
    );

    onchip_mem_arbiter #(.MAX_BURST(8), .READ_LATENCY(3)) dut3 (
        .clk(clk), .reset(reset),
        .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
        .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(d3M0Wait),
        .m0_readdata(d3M0Rdata), .m0_readdatavalid(d3M0Rdv),
        .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
        .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(d3M1Wait),
        .m1_readdata(d3M1Rdata), .m1_readdatavalid(d3M1Rdv),
        .mem_address(d3MemAddr), .mem_byteenable(d3MemBe), .mem_chipselect(d3MemCs),
        .mem_write(d3MemWr), .mem_writedata(d3MemWdata), .mem_clken(d3MemClken),
        .mem_readdata(d3MemRdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Unwritten RAM words read back as a recognisable pattern of their address.
    function automatic logic [31:0] memInit(logic [14:0] a);
        return 32'hC0DE_0000 | {17'd0, a};
    endfunction

    function automatic logic [31:0] mergeWord(logic [31:0] old, logic [31:0] wd, logic [3:0] be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
        return r;
    endfunction

    // RAM model for the latency-1 instance.
    logic [31:0] ram1 [0:32767];
    bit          ram1Wr [0:32767];
    logic [31:0] rd1;
    always @(posedge clk) begin
        if (d1MemCs && d1MemWr) begin
            ram1[d1MemAddr]   <= mergeWord(ram1Wr[d1MemAddr] ? ram1[d1MemAddr] : memInit(d1MemAddr), d1MemWdata, d1MemBe);
            ram1Wr[d1MemAddr] <= 1'b1;
        end else if (d1MemCs) begin
            rd1 <= ram1Wr[d1MemAddr] ? ram1[d1MemAddr] : memInit(d1MemAddr);
        end
    end
    assign d1MemRdata = rd1;

    // RAM model for the latency-3 instance.
    logic [31:0] ram3 [0:32767];
    bit          ram3Wr [0:32767];
    logic [31:0] rd3p0, rd3p1, rd3p2;
    always @(posedge clk) begin
        if (d3MemCs && d3MemWr) begin
            ram3[d3MemAddr]   <= mergeWord(ram3Wr[d3MemAddr] ? ram3[d3MemAddr] : memInit(d3MemAddr), d3MemWdata, d3MemBe);
            ram3Wr[d3MemAddr] <= 1'b1;
        end else if (d3MemCs) begin
            rd3p0 <= ram3Wr[d3MemAddr] ? ram3[d3MemAddr] : memInit(d3MemAddr);
        end
        rd3p1 <= rd3p0;
        rd3p2 <= rd3p1;
    end
    assign d3MemRdata = rd3p2;

    typedef struct {
        bit          rst;
        bit          r0;
        logic [14:0] a0;
        bit          r1, w1;
        logic [14:0] a1;
        logic [3:0]  be1;
        logic [31:0] wd1;
        bit          eCs, eWr;
        logic [14:0] eAddr;
        bit          eW0, eW1, eRdv0, eRdv1;
        logic [31:0] eData;
    } vec_t;

    function automatic vec_t mk(bit rst, bit r0, logic [14:0] a0, bit r1, bit w1, logic [14:0] a1,
                                logic [3:0] be1, logic [31:0] wd1, bit eCs, bit eWr, logic [14:0] eAddr,
                                bit eW0, bit eW1, bit eRdv0, bit eRdv1, logic [31:0] eData);
        vec_t v;
        v.rst = rst; v.r0 = r0; v.a0 = a0; v.r1 = r1; v.w1 = w1; v.a1 = a1;
        v.be1 = be1; v.wd1 = wd1; v.eCs = eCs; v.eWr = eWr; v.eAddr = eAddr;
        v.eW0 = eW0; v.eW1 = eW1; v.eRdv0 = eRdv0; v.eRdv1 = eRdv1; v.eData = eData;
        return v;
    endfunction

    task automatic checkOutput(string name, logic [63:0] act, logic [63:0] exp);
        testsRun++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idleInputs();
        m0_read = 0; m0_write = 0; m0_address = '0; m0_byteenable = 4'hF; m0_writedata = 32'h1111_1111;
        m1_read = 0; m1_write = 0; m1_address = '0; m1_byteenable = 4'hF; m1_writedata = 32'h2222_2222;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(vec_t v);
        idleInputs();
        reset = v.rst;
        m0_read = v.r0; m0_address = v.a0;
        m1_read = v.r1; m1_write = v.w1; m1_address = v.a1;
        m1_byteenable = v.be1; m1_writedata = v.wd1;
    endtask

    task automatic checkVector(int i, vec_t v);
        string p;
        p = $sformatf("v%0d ", i);
        checkOutput({p, "chipselect"}, d1MemCs, v.eCs);
        checkOutput({p, "m0_waitrequest"}, d1M0Wait, v.eW0);
        checkOutput({p, "m1_waitrequest"}, d1M1Wait, v.eW1);
        checkOutput({p, "m0_readdatavalid"}, d1M0Rdv, v.eRdv0);
        checkOutput({p, "m1_readdatavalid"}, d1M1Rdv, v.eRdv1);
        checkOutput({p, "mem_clken"}, d1MemClken, 1'b1);
        if (v.eCs) begin
            checkOutput({p, "mem_address"}, d1MemAddr, v.eAddr);
            checkOutput({p, "mem_write"}, d1MemWr, v.eWr);
        end
        if (v.eWr) begin
            checkOutput({p, "mem_byteenable"}, d1MemBe, v.be1);
            checkOutput({p, "mem_writedata"}, d1MemWdata, v.wd1);
        end
        if (v.eRdv0) checkOutput({p, "m0_readdata"}, d1M0Rdata, v.eData);
        if (v.eRdv1) checkOutput({p, "m1_readdata"}, d1M1Rdata, v.eData);
    endtask

    task automatic doReset();
        idleInputs();
        reset = 1;
        @(negedge clk);
        checkOutput("reset chipselect", {d1MemCs, d3MemCs}, 2'b00);
        checkOutput("reset readdatavalid", {d1M0Rdv, d1M1Rdv, d3M0Rdv, d3M1Rdv}, 4'b0000);
        checkOutput("reset clken", {d1MemClken, d3MemClken}, 2'b11);
        nextCycle();
        reset = 0;
    endtask

    // m0 streams 20 writes while m1 holds one read: m1 must win after exactly 8 m0 grants.
    task automatic runBurstSequence();
        int m0Sent = 0, m0Before = 0, m1Wait = 0, m1GrantCyc = -1, m1RdvCyc = -1, spur0 = 0;
        bit m1Done = 0, m0Resumed = 0;
        logic [31:0] m1Data = '0;
        doReset();
        for (int cyc = 0; cyc < 24; cyc++) begin
            idleInputs();
            if (m0Sent < 20) begin
                m0_write = 1; m0_address = 15'h200 + 15'(m0Sent);
                m0_writedata = 32'(m0Sent); m0_byteenable = 4'hF;
            end
            if (!m1Done) begin
                m1_read = 1; m1_address = 15'h300;
            end
            @(negedge clk);
            if (d1M1Rdv) begin m1RdvCyc = cyc; m1Data = d1M1Rdata; end
            if (d1M0Rdv) spur0++;
            if (m0_write && !d1M0Wait && d1MemCs) begin
                if (m1GrantCyc < 0) m0Before++;
                else if (cyc == m1GrantCyc + 1) m0Resumed = 1;
                m0Sent++;
            end
            if (m1_read && d1M1Wait) m1Wait++;
            if (m1_read && !d1M1Wait && d1MemCs) begin m1GrantCyc = cyc; m1Done = 1; end
            nextCycle();
        end
        idleInputs();
        checkOutput("burst m0 grants before m1", m0Before, 8);
        checkOutput("burst m1 waitrequest cycles", m1Wait, 8);
        checkOutput("burst m1 grant cycle", m1GrantCyc, 8);
        checkOutput("burst m0 resumes", m0Resumed, 1);
        checkOutput("burst m1 rdv cycle", m1RdvCyc, 9);
        checkOutput("burst m1 readdata", m1Data, 32'hC0DE_0300);
        checkOutput("burst writes total", m0Sent, 20);
        checkOutput("burst spurious m0 rdv", spur0, 0);
    endtask

    // Reset lands while an m1 read is in flight in the latency-3 instance.
    task automatic runResetMidRead();
        int rdvSeen = 0;
        doReset();
        m1_read = 1; m1_address = 15'h060;
        @(negedge clk);
        checkOutput("midrst m1 granted", {d3MemCs, d3M1Wait, d3MemAddr}, {1'b1, 1'b0, 15'h060});
        nextCycle();
        idleInputs();
        reset = 1;
        @(negedge clk);
        checkOutput("midrst outputs in reset", {d3MemCs, d3M0Rdv, d3M1Rdv}, 3'b000);
        nextCycle();
        reset = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (d3M0Rdv || d3M1Rdv) rdvSeen++;
            nextCycle();
        end
        checkOutput("midrst no readdatavalid", rdvSeen, 0);
        m0_read = 1; m0_address = 15'h070;
        m1_read = 1; m1_address = 15'h071;
        @(negedge clk);
        checkOutput("midrst tie goes to m0", {d3M0Wait, d3M1Wait, d3MemAddr}, {1'b0, 1'b1, 15'h070});
        nextCycle();
        idleInputs();
        for (int c = 0; c < 5; c++) nextCycle();
    endtask

    typedef struct {
        bit          id;
        logic [14:0] addr;
        int          cyc;
    } pend_t;

    // Alternating reads on the latency-3 instance: each return must be 3 cycles
    // after its grant, on the issuing port, in issue order.
    task automatic runLatency3Sequence();
        pend_t q[$];
        pend_t p;
        int m0Left = 4, m1Left = 4, k0 = 0, k1 = 0, returned = 0, dualRdv = 0, orphanRdv = 0;
        bit m0Cool = 0, m1Cool = 0;
        doReset();
        for (int cyc = 0; cyc < 20; cyc++) begin
            idleInputs();
            if (m0Left > 0 && !m0Cool) begin m0_read = 1; m0_address = 15'h010 + 15'(k0); end
            if (m1Left > 0 && !m1Cool) begin m1_read = 1; m1_address = 15'h030 + 15'(k1); end
            @(negedge clk);
            if (d3M0Rdv && d3M1Rdv) begin
                dualRdv++;
            end else if (d3M0Rdv || d3M1Rdv) begin
                if (q.size() == 0) begin
                    orphanRdv++;
                end else begin
                    p = q.pop_front();
                    checkOutput($sformatf("lat3 r%0d port", returned), d3M1Rdv, p.id);
                    checkOutput($sformatf("lat3 r%0d latency", returned), cyc - p.cyc, 3);
                    checkOutput($sformatf("lat3 r%0d data", returned), d3M1Rdv ? d3M1Rdata : d3M0Rdata, memInit(p.addr));
                    returned++;
                end
            end
            if (m0_read && !d3M0Wait) begin
                q.push_back('{1'b0, m0_address, cyc}); k0++; m0Left--; m0Cool = 1;
            end else begin
                m0Cool = 0;
            end
            if (m1_read && !d3M1Wait) begin
                q.push_back('{1'b1, m1_address, cyc}); k1++; m1Left--; m1Cool = 1;
            end else begin
                m1Cool = 0;
            end
            nextCycle();
        end
        idleInputs();
        checkOutput("lat3 returned count", returned, 8);
        checkOutput("lat3 pending left", q.size(), 0);
        checkOutput("lat3 dual strobes", dualRdv, 0);
        checkOutput("lat3 orphan strobes", orphanRdv, 0);
    endtask

    vec_t vecs [13];

    initial begin
        reset = 1;
        idleInputs();
        vecs[0]  = mk(1, 0, 15'h000, 0, 0, 15'h000, 4'h0, 32'h0,        0, 0, 15'h000, 0, 0, 0, 0, 32'h0);
        vecs[1]  = mk(0, 1, 15'h010, 0, 0, 15'h000, 4'h0, 32'h0,        1, 0, 15'h010, 0, 0, 0, 0, 32'h0);
        vecs[2]  = mk(0, 0, 15'h000, 0, 0, 15'h000, 4'h0, 32'h0,        0, 0, 15'h000, 0, 0, 1, 0, 32'hC0DE_0010);
        vecs[3]  = mk(1, 0, 15'h000, 0, 0, 15'h000, 4'h0, 32'h0,        0, 0, 15'h000, 0, 0, 0, 0, 32'h0);
        vecs[4]  = mk(0, 1, 15'h020, 1, 0, 15'h030, 4'h0, 32'h0,        1, 0, 15'h020, 0, 1, 0, 0, 32'h0);
        vecs[5]  = mk(0, 0, 15'h000, 1, 0, 15'h030, 4'h0, 32'h0,        1, 0, 15'h030, 0, 0, 1, 0, 32'hC0DE_0020);
        vecs[6]  = mk(0, 0, 15'h000, 0, 0, 15'h000, 4'h0, 32'h0,        0, 0, 15'h000, 0, 0, 0, 1, 32'hC0DE_0030);
        vecs[7]  = mk(0, 0, 15'h000, 0, 1, 15'h100, 4'h3, 32'hDEAD_BEEF, 1, 1, 15'h100, 0, 0, 0, 0, 32'h0);
        vecs[8]  = mk(0, 1, 15'h100, 0, 0, 15'h000, 4'h0, 32'h0,        1, 0, 15'h100, 0, 0, 0, 0, 32'h0);
        vecs[9]  = mk(0, 0, 15'h000, 0, 0, 15'h000, 4'h0, 32'h0,        0, 0, 15'h000, 0, 0, 1, 0, 32'hC0DE_BEEF);
        vecs[10] = mk(0, 1, 15'h040, 1, 0, 15'h050, 4'h0, 32'h0,        1, 0, 15'h050, 1, 0, 0, 0, 32'h0);
        vecs[11] = mk(0, 1, 15'h040, 0, 0, 15'h000, 4'h0, 32'h0,        1, 0, 15'h040, 0, 0, 0, 1, 32'hC0DE_0050);
        vecs[12] = mk(0, 0, 15'h000, 0, 0, 15'h000, 4'h0, 32'h0,        0, 0, 15'h000, 0, 0, 1, 0, 32'hC0DE_0040);

        nextCycle();
        for (int i = 0; i < 13; i++) begin
            applyStimulus(vecs[i]);
            @(negedge clk);
            checkVector(i, vecs[i]);
            nextCycle();
        end
        reset = 0;
        idleInputs();

        runBurstSequence();
        runResetMidRead();
        runLatency3Sequence();

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
